// File: rtl/cplane_pkg.sv
// Shared types for the C-plane packet checker: FSM states, the common-header
// struct and the fixed header bit positions inside the 32-bit stream words.
package cplane_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        DROP    = 2'd2
    } state_e;

    typedef struct packed {
        logic       dir;
        logic [7:0] frame_id;
        logic [3:0] subframe_id;
        logic [5:0] slot_id;
        logic [5:0] start_sym;
        logic [7:0] num_sections;
        logic [7:0] section_type;
    } cplane_hdr_t;

    // Word 0 field positions
    localparam int DIR_BIT         = 31;
    localparam int FRAME_ID_LSB    = 16;
    localparam int SUBFRAME_ID_LSB = 12;
    localparam int SLOT_ID_LSB     = 6;
    localparam int START_SYM_LSB   = 0;
    // Word 1 field positions
    localparam int NUM_SECT_LSB    = 24;
    localparam int SECT_TYPE_LSB   = 16;

    function automatic cplane_hdr_t unpack_hdr(input logic [31:0] word0,
                                               input logic [31:0] word1);
        cplane_hdr_t h;
        h.dir          = word0[DIR_BIT];
        h.frame_id     = word0[FRAME_ID_LSB    +: 8];
        h.subframe_id  = word0[SUBFRAME_ID_LSB +: 4];
        h.slot_id      = word0[SLOT_ID_LSB     +: 6];
        h.start_sym    = word0[START_SYM_LSB   +: 6];
        h.num_sections = word1[NUM_SECT_LSB    +: 8];
        h.section_type = word1[SECT_TYPE_LSB   +: 8];
        return h;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides the increment.
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 inc_i,
    input  logic                 clr_i,
    output logic [CNT_WIDTH-1:0] count_o
);

    logic [CNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cplane_pkt_checker.sv
// Sink for the C-plane generator stream: checks sop/eop framing and packet
// length, publishes the common header of good packets and counts good/bad.
module cplane_pkt_checker
    import cplane_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_WORDS  = 12,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_sop,
    input  logic                  s_eop,
    input  logic                  stall,
    input  logic                  clr_cnt,
    output logic                  hdr_valid,
    output logic                  hdr_dir,
    output logic [7:0]            hdr_frame_id,
    output logic [3:0]            hdr_subframe_id,
    output logic [5:0]            hdr_slot_id,
    output logic [5:0]            hdr_start_sym,
    output logic [7:0]            hdr_num_sections,
    output logic [7:0]            hdr_section_type,
    output logic                  err_len,
    output logic                  err_sop,
    output logic [CNT_WIDTH-1:0]  good_cnt,
    output logic [CNT_WIDTH-1:0]  bad_cnt
);

    localparam int                WC_W     = $clog2(PKT_WORDS + 1);
    localparam logic [WC_W-1:0]   WC_ONE   = WC_W'(1);
    localparam logic [WC_W-1:0]   LAST_IDX = WC_W'(PKT_WORDS - 1);

    state_e                  state_q, state_d;
    logic [WC_W-1:0]         word_cnt_q, word_cnt_d;
    logic [DATA_WIDTH-1:0]   shadow0_q, shadow0_d;
    logic [DATA_WIDTH-1:0]   shadow1_q, shadow1_d;
    cplane_hdr_t             hdr_q, hdr_d;
    logic                    hdr_valid_q;
    logic                    err_len_q, err_sop_q;
    logic                    good_pkt, len_err, sop_err;
    logic                    beat;

    assign s_ready = ~stall;
    assign beat    = s_valid & ~stall;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        shadow0_d  = shadow0_q;
        shadow1_d  = shadow1_q;
        good_pkt   = 1'b0;
        len_err    = 1'b0;
        sop_err    = 1'b0;

        if (beat) begin
            case (state_q)
                IDLE: begin
                    if (s_sop && s_eop) begin
                        len_err = 1'b1;
                    end else if (s_sop) begin
                        shadow0_d  = s_data;
                        word_cnt_d = WC_ONE;
                        state_d    = PAYLOAD;
                    end else begin
                        sop_err = 1'b1;
                        state_d = s_eop ? IDLE : DROP;
                    end
                end
                PAYLOAD: begin
                    if (s_sop) begin
                        // A sop mid-packet abandons the old packet and restarts.
                        sop_err = 1'b1;
                        if (s_eop) begin
                            word_cnt_d = '0;
                            state_d    = IDLE;
                        end else begin
                            shadow0_d  = s_data;
                            word_cnt_d = WC_ONE;
                        end
                    end else begin
                        if (word_cnt_q == WC_ONE) begin
                            shadow1_d = s_data;
                        end
                        if (s_eop) begin
                            good_pkt   = (word_cnt_q == LAST_IDX);
                            len_err    = (word_cnt_q != LAST_IDX);
                            word_cnt_d = '0;
                            state_d    = IDLE;
                        end else if (word_cnt_q == LAST_IDX) begin
                            // Overlong: flagged once here, the tail is dropped quietly.
                            len_err    = 1'b1;
                            word_cnt_d = '0;
                            state_d    = DROP;
                        end else begin
                            word_cnt_d = word_cnt_q + WC_ONE;
                        end
                    end
                end
                DROP: begin
                    if (s_sop && !s_eop) begin
                        shadow0_d  = s_data;
                        word_cnt_d = WC_ONE;
                        state_d    = PAYLOAD;
                    end else if (s_eop) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    word_cnt_d = '0;
                    state_d    = IDLE;
                end
            endcase
        end

        hdr_d = good_pkt ? unpack_hdr(shadow0_d[31:0], shadow1_d[31:0]) : hdr_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            word_cnt_q  <= '0;
            shadow0_q   <= '0;
            shadow1_q   <= '0;
            hdr_q       <= '0;
            hdr_valid_q <= 1'b0;
            err_len_q   <= 1'b0;
            err_sop_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            shadow0_q   <= shadow0_d;
            shadow1_q   <= shadow1_d;
            hdr_q       <= hdr_d;
            hdr_valid_q <= good_pkt;
            err_len_q   <= len_err;
            err_sop_q   <= sop_err;
        end
    end

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_good_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc_i   (good_pkt),
        .clr_i   (clr_cnt),
        .count_o (good_cnt)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_bad_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc_i   (len_err | sop_err),
        .clr_i   (clr_cnt),
        .count_o (bad_cnt)
    );

    assign hdr_valid        = hdr_valid_q;
    assign hdr_dir          = hdr_q.dir;
    assign hdr_frame_id     = hdr_q.frame_id;
    assign hdr_subframe_id  = hdr_q.subframe_id;
    assign hdr_slot_id      = hdr_q.slot_id;
    assign hdr_start_sym    = hdr_q.start_sym;
    assign hdr_num_sections = hdr_q.num_sections;
    assign hdr_section_type = hdr_q.section_type;
    assign err_len          = err_len_q;
    assign err_sop          = err_sop_q;

endmodule

// File: tb/tb_cplane_pkt_checker.sv
// Directed bench for cplane_pkt_checker; a second instance with 2-bit
// counters shares the stimulus to exercise saturation.
module tb_cplane_pkt_checker;

    localparam logic [31:0] W0  = 32'h8012_A5C3;
    localparam logic [31:0] W1  = 32'h0401_0000;
    localparam logic [31:0] WB0 = 32'h0055_F0FF;
    localparam logic [31:0] WB1 = 32'h0902_0000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] s_data;
    logic        s_valid, s_sop, s_eop, stall, clr_cnt;

    logic        s_ready, hdr_valid, hdr_dir, err_len, err_sop;
    logic [7:0]  hdr_frame_id, hdr_num_sections, hdr_section_type;
    logic [3:0]  hdr_subframe_id;
    logic [5:0]  hdr_slot_id, hdr_start_sym;
    logic [15:0] good_cnt, bad_cnt;

    logic        sat_s_ready, sat_hdr_valid, sat_hdr_dir, sat_err_len, sat_err_sop;
    logic [7:0]  sat_frame_id, sat_num_sections, sat_section_type;
    logic [3:0]  sat_subframe_id;
    logic [5:0]  sat_slot_id, sat_start_sym;
    logic [1:0]  sat_good_cnt, sat_bad_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int n_hdr    = 0;
    int n_len    = 0;
    int cyc      = 0;
    bit stall_mode = 1'b0;

    always #5 clock = ~clock;

    cplane_pkt_checker dut (
        .clock(clock), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .s_sop(s_sop), .s_eop(s_eop), .stall(stall),
        .clr_cnt(clr_cnt), .hdr_valid(hdr_valid), .hdr_dir(hdr_dir),
        .hdr_frame_id(hdr_frame_id), .hdr_subframe_id(hdr_subframe_id),
        .hdr_slot_id(hdr_slot_id), .hdr_start_sym(hdr_start_sym),
        .hdr_num_sections(hdr_num_sections), .hdr_section_type(hdr_section_type),
        .err_len(err_len), .err_sop(err_sop), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    cplane_pkt_checker #(.CNT_WIDTH(2)) dut_sat (
        .clock(clock), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid),
        .s_ready(sat_s_ready), .s_sop(s_sop), .s_eop(s_eop), .stall(stall),
        .clr_cnt(clr_cnt), .hdr_valid(sat_hdr_valid), .hdr_dir(sat_hdr_dir),
        .hdr_frame_id(sat_frame_id), .hdr_subframe_id(sat_subframe_id),
        .hdr_slot_id(sat_slot_id), .hdr_start_sym(sat_start_sym),
        .hdr_num_sections(sat_num_sections), .hdr_section_type(sat_section_type),
        .err_len(sat_err_len), .err_sop(sat_err_sop), .good_cnt(sat_good_cnt),
        .bad_cnt(sat_bad_cnt)
    );

    always @(negedge clock) begin
        if (hdr_valid) n_hdr++;
        if (err_len)   n_len++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Offers one word and holds it until accepted; stall_mode blocks every 3rd cycle.
    task automatic send_word(input logic [31:0] d, input logic sop, input logic eop);
        bit acc;
        acc     = 1'b0;
        s_data  = d;
        s_sop   = sop;
        s_eop   = eop;
        s_valid = 1'b1;
        for (int k = 0; k < 20 && !acc; k++) begin
            stall = stall_mode && (cyc % 3 == 2);
            @(posedge clock);
            acc = !stall;
            cyc++;
            #1;
        end
        stall   = 1'b0;
        s_valid = 1'b0;
        s_sop   = 1'b0;
        s_eop   = 1'b0;
        if (!acc) check("send_timeout", 32'(acc), 32'd1);
    endtask

    task automatic send_pkt(input logic [31:0] w0, input logic [31:0] w1, input int n,
                            input bit clr_at_eop);
        for (int i = 0; i < n; i++) begin
            logic [31:0] d;
            d = (i == 0) ? w0 : (i == 1) ? w1 : 32'hD000_0000 + 32'(i);
            if (clr_at_eop && i == n - 1) clr_cnt = 1'b1;
            send_word(d, i == 0, i == n - 1);
            clr_cnt = 1'b0;
        end
    endtask

    task automatic do_reset();
        s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0; s_data = '0;
        stall   = 1'b0; clr_cnt = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    // Expected fields of W0/W1, computed by hand from the field map.
    task automatic check_std_hdr(input string pfx);
        check({pfx, "_dir"},       32'(hdr_dir),          32'h1);
        check({pfx, "_frame"},     32'(hdr_frame_id),     32'h12);
        check({pfx, "_subframe"},  32'(hdr_subframe_id),  32'hA);
        check({pfx, "_slot"},      32'(hdr_slot_id),      32'h17);
        check({pfx, "_start_sym"}, 32'(hdr_start_sym),    32'h03);
        check({pfx, "_num_sect"},  32'(hdr_num_sections), 32'h04);
        check({pfx, "_sect_type"}, 32'(hdr_section_type), 32'h01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_hdr, base_len;

        // Reset state
        s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0; s_data = '0;
        stall = 1'b0; clr_cnt = 1'b0; reset_n = 1'b0;
        #3;
        check("rst_good_cnt",  32'(good_cnt),     32'd0);
        check("rst_bad_cnt",   32'(bad_cnt),      32'd0);
        check("rst_hdr_valid", 32'(hdr_valid),    32'd0);
        check("rst_err",       32'({err_len, err_sop}), 32'd0);
        check("rst_frame",     32'(hdr_frame_id), 32'd0);
        check("rst_s_ready",   32'(s_ready),      32'd1);
        do_reset();

        // 8 back-to-back good packets
        base_hdr = n_hdr; base_len = n_len;
        repeat (8) send_pkt(W0, W1, 12, 1'b0);
        check("b2b_hdr_valid_pulse", 32'(hdr_valid), 32'd1);
        @(posedge clock); #1;
        check("b2b_hdr_valid_drop", 32'(hdr_valid), 32'd0);
        check("b2b_hdr_pulses", 32'(n_hdr - base_hdr), 32'd8);
        check("b2b_good_cnt", 32'(good_cnt), 32'd8);
        check("b2b_bad_cnt",  32'(bad_cnt),  32'd0);
        check("b2b_len_errs", 32'(n_len - base_len), 32'd0);
        check_std_hdr("b2b");

        // Backpressure
        do_reset();
        stall = 1'b1; #1;
        check("stall_ready_lo", 32'(s_ready), 32'd0);
        stall = 1'b0; #1;
        check("stall_ready_hi", 32'(s_ready), 32'd1);
        base_hdr = n_hdr;
        stall_mode = 1'b1; cyc = 0;
        repeat (8) send_pkt(W0, W1, 12, 1'b0);
        stall_mode = 1'b0;
        @(posedge clock); #1;
        check("stall_hdr_pulses", 32'(n_hdr - base_hdr), 32'd8);
        check("stall_good_cnt", 32'(good_cnt), 32'd8);
        check("stall_bad_cnt",  32'(bad_cnt),  32'd0);
        check_std_hdr("stall");

        // Short packet, then good packet
        do_reset();
        send_pkt(WB0, WB1, 11, 1'b0);
        check("short_err_len",   32'(err_len),   32'd1);
        check("short_err_sop",   32'(err_sop),   32'd0);
        check("short_hdr_valid", 32'(hdr_valid), 32'd0);
        check("short_bad_cnt",   32'(bad_cnt),   32'd1);
        check("short_hdr_kept",  32'(hdr_frame_id), 32'd0);
        send_pkt(W0, W1, 12, 1'b0);
        check("short_next_valid", 32'(hdr_valid), 32'd1);
        @(posedge clock); #1;
        check("short_next_good", 32'(good_cnt), 32'd1);
        check("short_next_bad",  32'(bad_cnt),  32'd1);
        check_std_hdr("short");

        // Overlong packet: 14 words, error on word 12
        do_reset();
        for (int i = 0; i < 14; i++) begin
            send_word((i == 0) ? WB0 : 32'hE000_0000 + 32'(i), i == 0, i == 13);
            if (i == 10) check("long_no_err_w11", 32'(err_len), 32'd0);
            if (i == 11) check("long_err_len_w12", 32'(err_len), 32'd1);
        end
        check("long_no_err_eop", 32'(err_len), 32'd0);
        check("long_bad_cnt",    32'(bad_cnt), 32'd1);
        check("long_good_cnt",   32'(good_cnt), 32'd0);
        send_pkt(W0, W1, 12, 1'b0);
        @(posedge clock); #1;
        check("long_next_good", 32'(good_cnt), 32'd1);
        check("long_next_bad",  32'(bad_cnt),  32'd1);

        // sop on word 5 restarts the packet
        do_reset();
        for (int i = 0; i < 4; i++)
            send_word((i == 0) ? WB0 : (i == 1) ? WB1 : 32'hC000_0000 + 32'(i), i == 0, 1'b0);
        send_word(W0, 1'b1, 1'b0);
        check("resop_err_sop", 32'(err_sop), 32'd1);
        check("resop_err_len", 32'(err_len), 32'd0);
        for (int i = 1; i < 12; i++)
            send_word((i == 1) ? W1 : 32'hB000_0000 + 32'(i), 1'b0, i == 11);
        check("resop_hdr_valid", 32'(hdr_valid), 32'd1);
        @(posedge clock); #1;
        check("resop_good", 32'(good_cnt), 32'd1);
        check("resop_bad",  32'(bad_cnt),  32'd1);
        check_std_hdr("resop");

        // Stray words in IDLE, DROP behaviour, single-word packet
        do_reset();
        send_word(32'h1111_1111, 1'b0, 1'b0);
        check("stray_err_sop", 32'(err_sop), 32'd1);
        send_word(32'h2222_2222, 1'b0, 1'b0);
        check("drop_quiet", 32'({err_len, err_sop}), 32'd0);
        send_word(32'h3333_3333, 1'b0, 1'b1);
        check("drop_eop_quiet", 32'({err_len, err_sop}), 32'd0);
        send_word(W0, 1'b1, 1'b1);
        check("single_err", 32'({err_len, err_sop}), 32'b10);
        check("single_bad", 32'(bad_cnt), 32'd2);
        send_word(32'h4444_4444, 1'b0, 1'b0);
        send_pkt(W0, W1, 12, 1'b0);
        @(posedge clock); #1;
        check("drop_restart_good", 32'(good_cnt), 32'd1);
        check("drop_restart_bad",  32'(bad_cnt),  32'd3);

        // Saturation, clear, async reset
        do_reset();
        repeat (5) send_pkt(W0, W1, 12, 1'b0);
        @(posedge clock); #1;
        check("sat_good_2bit", 32'(sat_good_cnt), 32'd3);
        check("sat_good_16bit", 32'(good_cnt), 32'd5);
        send_pkt(W0, W1, 12, 1'b1);
        check("clr_wins_good",  32'(good_cnt), 32'd0);
        check("clr_wins_sat",   32'(sat_good_cnt), 32'd0);
        check("clr_pkt_valid",  32'(hdr_valid), 32'd1);
        send_pkt(W0, W1, 12, 1'b0);
        check("pre_rst_good", 32'(good_cnt), 32'd1);
        for (int i = 0; i < 5; i++)
            send_word((i == 0) ? WB0 : 32'hA000_0000 + 32'(i), i == 0, 1'b0);
        reset_n = 1'b0;
        #1;
        check("async_good", 32'(good_cnt), 32'd0);
        check("async_bad",  32'(bad_cnt),  32'd0);
        check("async_hdr",  32'({hdr_dir, hdr_frame_id, hdr_num_sections, hdr_section_type}), 32'd0);
        check("async_strobes", 32'({hdr_valid, err_len, err_sop}), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        send_pkt(W0, W1, 12, 1'b0);
        @(posedge clock); #1;
        check("post_rst_good", 32'(good_cnt), 32'd1);
        check("post_rst_bad",  32'(bad_cnt),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
